// File: rtl/sysid_rom_reader_if.sv
// Bus between the system-ID ROM reader, its asynchronous ROM and the host.
// slave = reader side, master = ROM/host side.
interface sysid_rom_reader_if #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6
);
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic [ROM_WIDTH-1:0]     rom_data;
  logic                     scan_start;
  logic                     scan_done;
  logic [ROM_WIDTH-1:0]     checksum;
  logic                     checksum_ok;
  logic                     rd_req;
  logic [ROM_ADDR_BITS-1:0] rd_addr;
  logic                     rd_ready;
  logic [ROM_WIDTH-1:0]     rd_data;
  logic                     rd_valid;

  modport slave (
    output rom_addr, scan_done, checksum, checksum_ok, rd_ready, rd_data, rd_valid,
    input  rom_data, scan_start, rd_req, rd_addr
  );

  modport master (
    input  rom_addr, scan_done, checksum, checksum_ok, rd_ready, rd_data, rd_valid,
    output rom_data, scan_start, rd_req, rd_addr
  );
endinterface

// File: rtl/sysid_rom_reader.sv
// Checksums the system-ID ROM after reset or on request, and serves single
// host reads from it in between scans.
module sysid_rom_reader #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  sysid_rom_reader_if.slave  bus
);
  typedef enum logic [1:0] {
    SCAN = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic [ROM_ADDR_BITS-1:0] LAST_ADDR = {ROM_ADDR_BITS{1'b1}};

  state_t                   state, state_nxt;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic [ROM_WIDTH-1:0]     acc;
  logic [ROM_WIDTH-1:0]     sum;
  logic [ROM_WIDTH-1:0]     checksum;
  logic [ROM_WIDTH-1:0]     rd_data;
  logic                     checksum_ok;
  logic                     scan_done;
  logic                     rd_valid;
  logic                     last;
  logic                     ready;
  logic                     start;
  logic                     accept;

  assign sum    = acc + bus.rom_data;
  assign last   = (rom_addr == LAST_ADDR);
  // scan_start outranks a same-cycle read, so it also masks rd_ready
  assign ready  = (state == IDLE) && !bus.scan_start;
  assign start  = (state == IDLE) && bus.scan_start;
  assign accept = ready && bus.rd_req;

  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (last) state_nxt = IDLE;
      IDLE: begin
        if (start)       state_nxt = SCAN;
        else if (accept) state_nxt = READ;
      end
      READ:    state_nxt = IDLE;
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      acc         <= '0;
      checksum    <= '0;
      checksum_ok <= 1'b0;
      scan_done   <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        SCAN: begin
          acc <= sum;
          // last word: publish the total and park the address
          if (last) begin
            checksum    <= sum;
            checksum_ok <= (sum == '0);
            scan_done   <= 1'b1;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            scan_done   <= 1'b0;
            checksum_ok <= 1'b0;
            acc         <= '0;
            rom_addr    <= '0;
          end else if (accept) begin
            rom_addr <= bus.rd_addr;
          end
        end
        READ: begin
          rd_data  <= bus.rom_data;
          rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.scan_done   = scan_done;
  assign bus.checksum    = checksum;
  assign bus.checksum_ok = checksum_ok;
  assign bus.rd_ready    = ready;
  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
endmodule

// File: tb/tb_sysid_rom_reader.sv
// Directed bench for sysid_rom_reader: scan timing/checksum, table of host
// reads, scan_start/read priority, and reset aborts.
module tb_sysid_rom_reader;
  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] rom [64];

  sysid_rom_reader_if #(.ROM_WIDTH(32), .ROM_ADDR_BITS(6)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  sysid_rom_reader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_ramp();
    for (int i = 0; i < 64; i++) rom[i] = 32'(i + 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_scan_done"}, 32'(bus.scan_done), 32'd0);
    chk({tag, "_checksum"}, bus.checksum, 32'd0);
    chk({tag, "_checksum_ok"}, 32'(bus.checksum_ok), 32'd0);
    chk({tag, "_rd_data"}, bus.rd_data, 32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
  endtask

  // Steps until scan_done (bounded), checking that the scan never shows
  // rd_valid/rd_ready and that checksum holds old_ck until the scan ends.
  task automatic wait_scan(input string tag, input int pulse_at,
                           input logic [31:0] old_ck, input int exp_edges);
    int n = 0;
    int bad = 0;
    while (!bus.scan_done && n < 200) begin
      if (n == pulse_at) bus.scan_start = 1'b1;
      step();
      bus.scan_start = 1'b0;
      n++;
      if (bus.rd_valid) bad++;
      if (!bus.scan_done && (bus.rd_ready || bus.checksum !== old_ck)) bad++;
    end
    chk({tag, "_edges"}, 32'(n), 32'(exp_edges));
    chk({tag, "_quiet_scan"}, 32'(bad), 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    int n;
    vecs[0] = '{6'd0,  32'd1};
    vecs[1] = '{6'd5,  32'd6};
    vecs[2] = '{6'd31, 32'd32};
    vecs[3] = '{6'd63, 32'd64};
    vecs[4] = '{6'd17, 32'd18};

    rom_ramp();
    rst = 1'b1;
    bus.scan_start = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    repeat (3) step();
    chk_reset_vals("reset");

    // release reset with a read already pending
    rst = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd5;
    wait_scan("scan1", -1, 32'd0, 64);
    chk("scan1_checksum", bus.checksum, 32'h0000_0820);
    chk("scan1_ok", 32'(bus.checksum_ok), 32'd0);
    chk("pend_ready_idle", 32'(bus.rd_ready), 32'd1);
    step();
    bus.rd_req = 1'b0;
    chk("pend_ready_n1", 32'(bus.rd_ready), 32'd0);
    chk("pend_rom_addr", 32'(bus.rom_addr), 32'd5);
    chk("pend_valid_n1", 32'(bus.rd_valid), 32'd0);
    step();
    chk("pend_valid_n2", 32'(bus.rd_valid), 32'd1);
    chk("pend_data", bus.rd_data, 32'h0000_0006);
    step();
    chk("pend_valid_n3", 32'(bus.rd_valid), 32'd0);
    chk("pend_data_hold", bus.rd_data, 32'h0000_0006);

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tbl%0d_ready", i), 32'(bus.rd_ready), 32'd1);
      bus.rd_req = 1'b1;
      bus.rd_addr = vecs[i].addr;
      step();
      bus.rd_req = 1'b0;
      chk($sformatf("tbl%0d_ready_n1", i), 32'(bus.rd_ready), 32'd0);
      chk($sformatf("tbl%0d_valid_n1", i), 32'(bus.rd_valid), 32'd0);
      step();
      chk($sformatf("tbl%0d_valid_n2", i), 32'(bus.rd_valid), 32'd1);
      chk($sformatf("tbl%0d_data", i), bus.rd_data, vecs[i].data);
      step();
      chk($sformatf("tbl%0d_valid_n3", i), 32'(bus.rd_valid), 32'd0);
      chk($sformatf("tbl%0d_hold", i), bus.rd_data, vecs[i].data);
    end

    // scan_start during READ is ignored
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd2;
    step();
    bus.rd_req = 1'b0;
    bus.scan_start = 1'b1;
    chk("rdscan_ready", 32'(bus.rd_ready), 32'd0);
    step();
    bus.scan_start = 1'b0;
    chk("rdscan_valid", 32'(bus.rd_valid), 32'd1);
    chk("rdscan_data", bus.rd_data, 32'h0000_0003);
    chk("rdscan_done_kept", 32'(bus.scan_done), 32'd1);

    // scan_start beats rd_req; new ROM image sums to zero
    for (int i = 0; i < 63; i++) rom[i] = 32'd1;
    rom[63] = 32'hFFFF_FFC1;
    bus.scan_start = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd3;
    chk("prio_ready", 32'(bus.rd_ready), 32'd0);
    step();
    bus.scan_start = 1'b0;
    bus.rd_req = 1'b0;
    chk("prio_done_drop", 32'(bus.scan_done), 32'd0);
    chk("prio_ok_drop", 32'(bus.checksum_ok), 32'd0);
    chk("prio_ck_hold", bus.checksum, 32'h0000_0820);
    chk("prio_valid", 32'(bus.rd_valid), 32'd0);
    chk("prio_rom_addr", 32'(bus.rom_addr), 32'd0);
    wait_scan("scan2", 10, 32'h0000_0820, 64);
    chk("scan2_checksum", bus.checksum, 32'h0000_0000);
    chk("scan2_ok", 32'(bus.checksum_ok), 32'd1);

    // reset mid-scan at address 20
    rom_ramp();
    bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    n = 0;
    while (bus.rom_addr != 6'd20 && n < 100) begin
      step();
      n++;
    end
    chk("midscan_addr", 32'(bus.rom_addr), 32'd20);
    rst = 1'b1;
    step();
    chk_reset_vals("midscan_rst");
    rst = 1'b0;
    wait_scan("scan3", -1, 32'd0, 64);
    chk("scan3_checksum", bus.checksum, 32'h0000_0820);

    // reset mid-read: no rd_valid pulse, scan restarts from 0
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'd7;
    step();
    bus.rd_req = 1'b0;
    rst = 1'b1;
    step();
    chk_reset_vals("midread_rst");
    rst = 1'b0;
    wait_scan("scan4", -1, 32'd0, 64);
    chk("scan4_checksum", bus.checksum, 32'h0000_0820);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
